// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache main-memory arbiter.
// Holds the FSM state encoding, the grant identifiers and the default bus widths.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 28;
   localparam int DATA_W_DEF = 128;
   localparam int CNT_W_DEF  = 16;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      DONE_I,
      DONE_D
   } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, and on a tie
// the side that was not granted last time wins.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   output logic gnt_i,
   output logic gnt_d
);

   assign gnt_i = req_i && (!req_d || (last_grant == GRANT_D));
   assign gnt_d = req_d && (!req_i || (last_grant == GRANT_I));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises I-cache and D-cache block transactions onto one memory port.
// Optional statistics counters are built when MEM_ARB_STAT_EN is defined.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_STAT_EN
   ,parameter int CNT_W = CNT_W_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mem_read,
   input  logic [ADDR_W-1:0] i_mem_addr,
   output logic [DATA_W-1:0] i_mem_rdata,
   output logic              i_mem_ready,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [DATA_W-1:0] d_mem_wdata,
   output logic [DATA_W-1:0] d_mem_rdata,
   output logic              d_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
`ifdef MEM_ARB_STAT_EN
   ,output logic [CNT_W-1:0] stat_i_grants
   ,output logic [CNT_W-1:0] stat_d_grants
   ,output logic [CNT_W-1:0] stat_conflicts
`endif
);

   arb_state_t        state_q;
   logic              last_grant_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              i_ready_q;
   logic              d_ready_q;

   logic i_req;
   logic d_req;
   logic gnt_i;
   logic gnt_d;

   assign i_req = i_mem_read;
   assign d_req = d_mem_read || d_mem_write;

   rr_arb2 u_rr (
      .req_i      (i_req),
      .req_d      (d_req),
      .last_grant (last_grant_q),
      .gnt_i      (gnt_i),
      .gnt_d      (gnt_d)
   );

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_I;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
      end else begin
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (gnt_i) begin
                  state_q      <= BUSY_I;
                  last_grant_q <= GRANT_I;
                  mem_addr_q   <= i_mem_addr;
                  mem_read_q   <= 1'b1;
               end else if (gnt_d) begin
                  // A simultaneous read and write is treated as a plain write-back.
                  state_q      <= BUSY_D;
                  last_grant_q <= GRANT_D;
                  mem_addr_q   <= d_mem_addr;
                  mem_wdata_q  <= d_mem_wdata;
                  mem_read_q   <= !d_mem_write;
                  mem_write_q  <= d_mem_write;
               end
            end
            BUSY_I: begin
               if (mem_ready) begin
                  state_q    <= DONE_I;
                  mem_read_q <= 1'b0;
                  i_rdata_q  <= mem_rdata;
                  i_ready_q  <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_ready) begin
                  state_q     <= DONE_D;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  if (mem_read_q) begin
                     d_rdata_q <= mem_rdata;
                  end
                  d_ready_q   <= 1'b1;
               end
            end
            DONE_I, DONE_D: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign i_mem_rdata = i_rdata_q;
   assign d_mem_rdata = d_rdata_q;
   assign i_mem_ready = i_ready_q;
   assign d_mem_ready = d_ready_q;

`ifdef MEM_ARB_STAT_EN
   logic [CNT_W-1:0] stat_i_q, stat_i_d;
   logic [CNT_W-1:0] stat_d_q, stat_d_d;
   logic [CNT_W-1:0] conf_q, conf_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      stat_i_d = stat_i_q;
      stat_d_d = stat_d_q;
      conf_d   = conf_q;
      if (state_q == IDLE) begin
         if (gnt_i && !(&stat_i_q)) begin
            stat_i_d = stat_i_q + 1'b1;
         end
         if (gnt_d && !(&stat_d_q)) begin
            stat_d_d = stat_d_q + 1'b1;
         end
         if (i_req && d_req && !(&conf_q)) begin
            conf_d = conf_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_i_q <= '0;
         stat_d_q <= '0;
         conf_q   <= '0;
      end else begin
         stat_i_q <= stat_i_d;
         stat_d_q <= stat_d_d;
         conf_q   <= conf_d;
      end
   end

   assign stat_i_grants  = stat_i_q;
   assign stat_d_grants  = stat_d_q;
   assign stat_conflicts = conf_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the stats test is built
// only when MEM_ARB_STAT_EN is defined.
module tb_mem_bus_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_mem_read;
   logic [AW-1:0] i_mem_addr;
   logic [DW-1:0] i_mem_rdata;
   logic          i_mem_ready;
   logic          d_mem_read;
   logic          d_mem_write;
   logic [AW-1:0] d_mem_addr;
   logic [DW-1:0] d_mem_wdata;
   logic [DW-1:0] d_mem_rdata;
   logic          d_mem_ready;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
`ifdef MEM_ARB_STAT_EN
   logic [15:0]   stat_i_grants;
   logic [15:0]   stat_d_grants;
   logic [15:0]   stat_conflicts;
`endif

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] i_last;
   logic [DW-1:0] d_last;

   mem_bus_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .i_mem_read  (i_mem_read),
      .i_mem_addr  (i_mem_addr),
      .i_mem_rdata (i_mem_rdata),
      .i_mem_ready (i_mem_ready),
      .d_mem_read  (d_mem_read),
      .d_mem_write (d_mem_write),
      .d_mem_addr  (d_mem_addr),
      .d_mem_wdata (d_mem_wdata),
      .d_mem_rdata (d_mem_rdata),
      .d_mem_ready (d_mem_ready),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready)
`ifdef MEM_ARB_STAT_EN
      ,.stat_i_grants  (stat_i_grants)
      ,.stat_d_grants  (stat_d_grants)
      ,.stat_conflicts (stat_conflicts)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      i_mem_read  = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      mem_ready   = 1'b0;
      tick();
      tick();
      rst    = 1'b0;
      i_last = '0;
      d_last = '0;
   endtask

   // Serves one memory transaction that the bench expects to be granted next.
   task automatic do_xact(input bit exp_d, input bit exp_wr, input logic [AW-1:0] exp_addr,
                          input logic [DW-1:0] exp_wdata, input logic [DW-1:0] rd,
                          input int lat, input bit rel_i, input bit rel_d);
      logic [AW-1:0] ia, da;
      logic [DW-1:0] dw;
      int n;
      n = 0;
      while (!(mem_read || mem_write) && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!(mem_read || mem_write)) begin
         $display("FAIL xact_grant: no strobe within %0d cycles (addr exp %h)", n, exp_addr);
         failures++;
         return;
      end
      checks++;
      if (mem_addr !== exp_addr) begin
         $display("FAIL grant_addr: got %h expected %h", mem_addr, exp_addr); failures++;
      end
      checks++;
      if ({mem_read, mem_write} !== {!exp_wr, exp_wr}) begin
         $display("FAIL grant_op: rd/wr got %b%b expected %b%b", mem_read, mem_write, !exp_wr, exp_wr);
         failures++;
      end
      if (exp_wr) begin
         checks++;
         if (mem_wdata !== exp_wdata) begin
            $display("FAIL grant_wdata: got %h expected %h", mem_wdata, exp_wdata); failures++;
         end
      end
      ia = i_mem_addr; da = d_mem_addr; dw = d_mem_wdata;
      i_mem_addr = ~ia; d_mem_addr = ~da; d_mem_wdata = ~dw;
      repeat (lat - 1) tick();
      checks++;
      if ({mem_read, mem_write, mem_addr} !== {!exp_wr, exp_wr, exp_addr}) begin
         $display("FAIL busy_hold: rd/wr/addr got %b%b %h expected %b%b %h",
                  mem_read, mem_write, mem_addr, !exp_wr, exp_wr, exp_addr);
         failures++;
      end
      i_mem_addr = ia; d_mem_addr = da; d_mem_wdata = dw;
      mem_ready = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (!exp_wr) begin
         if (exp_d) d_last = rd;
         else       i_last = rd;
      end
      checks++;
      if ({i_mem_ready, d_mem_ready} !== {!exp_d, exp_d}) begin
         $display("FAIL done_ready: i/d got %b%b expected %b%b", i_mem_ready, d_mem_ready, !exp_d, exp_d);
         failures++;
      end
      checks++;
      if ({mem_read, mem_write} !== 2'b00) begin
         $display("FAIL done_strobe: rd/wr got %b%b expected 00", mem_read, mem_write); failures++;
      end
      checks++;
      if (i_mem_rdata !== i_last) begin
         $display("FAIL i_rdata: got %h expected %h", i_mem_rdata, i_last); failures++;
      end
      checks++;
      if (d_mem_rdata !== d_last) begin
         $display("FAIL d_rdata: got %h expected %h", d_mem_rdata, d_last); failures++;
      end
      if (rel_i) i_mem_read = 1'b0;
      if (rel_d) begin
         d_mem_read  = 1'b0;
         d_mem_write = 1'b0;
      end
      tick();
      checks++;
      if ({i_mem_ready, d_mem_ready, mem_read, mem_write} !== 4'b0000) begin
         $display("FAIL after_done: i_rdy/d_rdy/rd/wr got %b%b%b%b expected 0000",
                  i_mem_ready, d_mem_ready, mem_read, mem_write);
         failures++;
      end
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      i_mem_read  = 1'b1;
      i_mem_addr  = 28'h123_4567;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_mem_addr  = '0;
      d_mem_wdata = '0;
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      tick();
      tick();
      checks++;
      if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000 || mem_addr !== '0 ||
          mem_wdata !== '0 || i_mem_rdata !== '0 || d_mem_rdata !== '0) begin
         $display("FAIL reset_outputs: rd=%b wr=%b irdy=%b drdy=%b addr=%h expected all zero",
                  mem_read, mem_write, i_mem_ready, d_mem_ready, mem_addr);
         failures++;
      end
      rst        = 1'b0;
      i_mem_read = 1'b0;
      i_last     = '0;
      d_last     = '0;
      tick();
      checks++;
      if ({mem_read, mem_write} !== 2'b00) begin
         $display("FAIL reset_idle: rd/wr got %b%b expected 00", mem_read, mem_write); failures++;
      end
   endtask

   task automatic test_i_read();
      i_mem_read = 1'b1;
      i_mem_addr = 28'h000_0010;
      checks++;
      if (mem_read !== 1'b0) begin
         $display("FAIL i_read_latency0: mem_read got %b expected 0", mem_read); failures++;
      end
      tick();
      checks++;
      if (mem_read !== 1'b1) begin
         $display("FAIL i_read_latency1: mem_read got %b expected 1", mem_read); failures++;
      end
      do_xact(1'b0, 1'b0, 28'h000_0010, '0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 4, 1'b1, 1'b0);
   endtask

   task automatic test_ready_ignored();
      mem_ready = 1'b1;
      mem_rdata = 128'hBAD0_BAD0;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      checks++;
      if ({i_mem_ready, d_mem_ready, mem_read, mem_write} !== 4'b0000 ||
          i_mem_rdata !== i_last || d_mem_rdata !== d_last) begin
         $display("FAIL idle_ready: irdy/drdy/rd/wr got %b%b%b%b expected 0000, i_rdata %h expected %h",
                  i_mem_ready, d_mem_ready, mem_read, mem_write, i_mem_rdata, i_last);
         failures++;
      end
      tick();
      checks++;
      if ({i_mem_ready, d_mem_ready} !== 2'b00) begin
         $display("FAIL idle_ready2: i/d got %b%b expected 00", i_mem_ready, d_mem_ready); failures++;
      end
   endtask

   task automatic test_conflict();
      do_reset();
      i_mem_read  = 1'b1;
      i_mem_addr  = 28'h000_0020;
      d_mem_write = 1'b1;
      d_mem_addr  = 28'h000_0030;
      d_mem_wdata = 128'hC0FFEE00_11223344_55667788_99AABBCC;
      do_xact(1'b1, 1'b1, 28'h000_0030, 128'hC0FFEE00_11223344_55667788_99AABBCC,
              128'hFFFF, 1, 1'b0, 1'b1);
      do_xact(1'b0, 1'b0, 28'h000_0020, '0, 128'h2222_0002, 2, 1'b1, 1'b0);
   endtask

   task automatic test_alternate();
      i_mem_read  = 1'b1;
      i_mem_addr  = 28'h000_0100;
      d_mem_read  = 1'b1;
      d_mem_write = 1'b0;
      d_mem_addr  = 28'h000_0200;
      for (int k = 0; k < 6; k++) begin
         logic is_d;
         is_d = (k % 2 == 0);
         do_xact(is_d, 1'b0, is_d ? 28'h000_0200 : 28'h000_0100, '0,
                 {96'h0, 32'hA000_0000 + 32'(k)}, 2, k == 5, k == 5);
      end
   endtask

   task automatic test_rw_both();
      d_mem_read  = 1'b1;
      d_mem_write = 1'b1;
      d_mem_addr  = 28'h000_0060;
      d_mem_wdata = 128'h11111111_22222222_33333333_00000006;
      do_xact(1'b1, 1'b1, 28'h000_0060, 128'h11111111_22222222_33333333_00000006,
              128'h5555_5555, 3, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      d_mem_read = 1'b1;
      d_mem_addr = 28'h000_0040;
      tick();
      checks++;
      if (mem_read !== 1'b1) begin
         $display("FAIL mid_busy: mem_read got %b expected 1", mem_read); failures++;
      end
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000) begin
         $display("FAIL mid_reset: rd/wr/irdy/drdy got %b%b%b%b expected 0000",
                  mem_read, mem_write, i_mem_ready, d_mem_ready);
         failures++;
      end
      rst        = 1'b0;
      d_mem_read = 1'b0;
      i_last     = '0;
      d_last     = '0;
      tick();
      checks++;
      if (d_mem_ready !== 1'b0 || d_mem_rdata !== '0) begin
         $display("FAIL mid_after: d_ready got %b expected 0, d_rdata %h expected 0", d_mem_ready, d_mem_rdata);
         failures++;
      end
      i_mem_read = 1'b1;
      i_mem_addr = 28'h000_0050;
      do_xact(1'b0, 1'b0, 28'h000_0050, '0, 128'h5050_5050, 2, 1'b1, 1'b0);
   endtask

`ifdef MEM_ARB_STAT_EN
   task automatic test_stats();
      do_reset();
      i_mem_read = 1'b1;
      i_mem_addr = 28'h000_0300;
      d_mem_read = 1'b1;
      d_mem_addr = 28'h000_0310;
      do_xact(1'b1, 1'b0, 28'h000_0310, '0, 128'h31, 1, 1'b0, 1'b0);
      do_xact(1'b0, 1'b0, 28'h000_0300, '0, 128'h32, 1, 1'b0, 1'b0);
      do_xact(1'b1, 1'b0, 28'h000_0310, '0, 128'h33, 1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         i_mem_read = 1'b1;
         do_xact(1'b0, 1'b0, 28'h000_0300, '0, 128'h40 + 128'(k), 1, 1'b1, 1'b0);
      end
      for (int k = 0; k < 2; k++) begin
         d_mem_read = 1'b1;
         do_xact(1'b1, 1'b0, 28'h000_0310, '0, 128'h50 + 128'(k), 1, 1'b0, 1'b1);
      end
      checks++;
      if ({stat_conflicts, stat_i_grants, stat_d_grants} !== {16'd3, 16'd5, 16'd4}) begin
         $display("FAIL stats: conflicts/i/d got %0d/%0d/%0d expected 3/5/4",
                  stat_conflicts, stat_i_grants, stat_d_grants);
         failures++;
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_i_read();
      test_ready_ignored();
      test_conflict();
      test_alternate();
      test_rw_both();
      test_reset_mid();
`ifdef MEM_ARB_STAT_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
